// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: request/response front end for the single-precision FPU core.
// Requests are accepted on a valid/ready handshake and registered onto the
// core's inputs. Each accepted request's {valid, tag} is carried through a
// tracking shift register that is as long as the core's latency, plus one
// stage. When an entry leaves that register, the core's result and flags are
// captured into a first-word-fall-through FIFO. Credits keep the FIFO from
// overflowing: an accept is allowed only while
// in-flight + FIFO occupancy < FIFO_DEPTH.
//
// Handshake semantics, for both the request and the response port:
// - A transfer happens on a rising clk edge where valid and ready are both 1.
// - valid never depends on ready.
// - req_ready depends only on registered state, never on req_valid.
// - While rsp_valid is 1, rsp_data, rsp_flags and rsp_tag hold the FIFO head
//   and stay stable until that head is popped.
module fpu_issue_queue #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [1:0]       req_rmode,
  input  logic [31:0]      req_opa,
  input  logic [31:0]      req_opb,
  input  logic [TAG_W-1:0] req_tag,
  output logic [2:0]       fpu_op,
  output logic [1:0]       fpu_rmode,
  output logic [31:0]      opa,
  output logic [31:0]      opb,
  input  logic [31:0]      fpu_out,
  input  logic [7:0]       fpu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [7:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Credit and FIFO bookkeeping
  logic [CW-1:0]    out_cnt;
  logic [CW-1:0]    out_cnt_nxt;
  logic [CW-1:0]    fifo_cnt;
  logic [CW-1:0]    fifo_cnt_nxt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Tracking shift register: stage 0 is loaded on the accept edge
  logic [LATENCY:0] sr_valid;
  logic [TAG_W-1:0] sr_tag [LATENCY+1];

  // Result FIFO storage
  logic [31:0]      mem_data  [FIFO_DEPTH];
  logic [7:0]       mem_flags [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag   [FIFO_DEPTH];

  logic accept;
  logic pop;
  logic capture;

  assign req_ready = (out_cnt < DEPTH_C);
  assign busy      = (out_cnt != '0);
  assign rsp_valid = (fifo_cnt != '0);

  assign accept  = req_valid && req_ready;
  assign pop     = rsp_valid && rsp_ready;
  assign capture = sr_valid[LATENCY];

  // Response fields are forced to 0 while the FIFO is empty, so the outputs
  // read 0 out of reset even though the storage array is never cleared.
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr]  : '0;
  assign rsp_flags = rsp_valid ? mem_flags[rd_ptr] : '0;
  assign rsp_tag   = rsp_valid ? mem_tag[rd_ptr]   : '0;

  // Next counts.
  // outstanding: moves only on accept and pop.
  // FIFO occupancy: moves only on capture and pop.
  always_comb begin
    out_cnt_nxt  = out_cnt;
    fifo_cnt_nxt = fifo_cnt;
    if (accept && !pop) begin
      out_cnt_nxt = out_cnt + CW'(1);
    end else if (pop && !accept) begin
      out_cnt_nxt = out_cnt - CW'(1);
    end
    if (capture && !pop) begin
      fifo_cnt_nxt = fifo_cnt + CW'(1);
    end else if (pop && !capture) begin
      fifo_cnt_nxt = fifo_cnt - CW'(1);
    end
  end

  // Core operand and mode registers: load on accept, hold through idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_op    <= '0;
      fpu_rmode <= '0;
      opa       <= '0;
      opb       <= '0;
    end else if (accept) begin
      fpu_op    <= req_op;
      fpu_rmode <= req_rmode;
      opa       <= req_opa;
      opb       <= req_opb;
    end
  end

  // Track each accepted request alongside the core pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_valid <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        sr_tag[i] <= '0;
      end
    end else begin
      sr_valid  <= {sr_valid[LATENCY-1:0], accept};
      sr_tag[0] <= req_tag;
      for (int i = 1; i <= LATENCY; i++) begin
        sr_tag[i] <= sr_tag[i-1];
      end
    end
  end

  // Capture the core result into the FIFO as its tracking entry leaves.
  // At full, a same-edge pop frees the head slot that this write lands on.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      mem_data[wr_ptr]  <= fpu_out;
      mem_flags[wr_ptr] <= fpu_flags;
      mem_tag[wr_ptr]   <= sr_tag[LATENCY];
    end
  end

  // Pointers and counters; pointers wrap naturally modulo FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_cnt  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      out_cnt  <= out_cnt_nxt;
      fifo_cnt <= fifo_cnt_nxt;
    end
  end

  // Simulation checks on credit consistency.
  // The credit count never exceeds FIFO_DEPTH and always equals the
  // in-flight entries plus the FIFO occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (out_cnt <= DEPTH_C);
      assert (fifo_cnt <= out_cnt);
      assert (int'(out_cnt) == $countones(sr_valid) + int'(fifo_cnt));
      assert (!(pop && out_cnt == '0));
    end
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: the core is modelled as an ideal LATENCY-stage
// pipeline. The reference model is the list of accepted-but-not-yet-returned
// requests, in order. Each entry carries the cycle at which its response
// must first be visible. Outstanding count, req_ready, busy, rsp_valid and
// the head contents all follow from that list.
module tb_fpu_issue_queue;

  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 4;
  localparam int EW         = 40 + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [1:0]       req_rmode;
  logic [31:0]      req_opa;
  logic [31:0]      req_opb;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       fpu_op;
  logic [1:0]       fpu_rmode;
  logic [31:0]      opa;
  logic [31:0]      opb;
  logic [31:0]      fpu_out;
  logic [7:0]       fpu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [7:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  fpu_issue_queue #(
    .LATENCY(LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_rmode(req_rmode),
    .req_opa(req_opa),
    .req_opb(req_opb),
    .req_tag(req_tag),
    .fpu_op(fpu_op),
    .fpu_rmode(fpu_rmode),
    .opa(opa),
    .opb(opb),
    .fpu_out(fpu_out),
    .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag),
    .busy(busy)
  );

  // ---------------- core stand-in ----------------
  // Exact IEEE results for the 24 / 10 operand pair. Any other operands get
  // an arbitrary but deterministic mix of the inputs.
  // Return value is {flags, result}.
  function automatic logic [39:0] core_fn(input logic [2:0] op, input logic [1:0] rm,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [39:0] r;
    r[31:0]  = (a ^ {b[15:0], b[31:16]}) + {27'd0, op, rm};
    r[39:32] = a[7:0] ^ b[15:8] ^ {op, rm, 3'b101};
    if (a == 32'h41C0_0000 && b == 32'h4120_0000) begin
      case (op)
        3'd0:    r = {8'h00, 32'h4208_0000};
        3'd1:    r = {8'h00, 32'h4160_0000};
        3'd2:    r = {8'h00, 32'h4370_0000};
        3'd3:    r = {8'h10, 32'h4019_999A};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  logic [39:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(fpu_op, fpu_rmode, opa, opb);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign fpu_out   = core_pipe[LATENCY-1][31:0];
  assign fpu_flags = core_pipe[LATENCY-1][39:32];

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc;
  bit inited;
  logic [EW-1:0]    exp_q[$];        // {flags, data, tag} in acceptance order
  int               avail_q[$];      // cycle from which each entry is visible
  int               pop_tag_hist[$];
  int               pop_cyc_hist[$];
  logic [2:0]       exp_op;
  logic [1:0]       exp_rmode;
  logic [31:0]      exp_opa;
  logic [31:0]      exp_opb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  // Checks every cycle at the falling edge. It then applies the transfers
  // that the next rising edge will perform to the model.
  initial begin : compare
    logic [EW-1:0] h;
    logic exp_rv;
    logic acc;
    logic pp;
    cyc = 0;
    inited = 0;
    forever begin
      @(negedge clk);
      cyc++;
      exp_rv = (exp_q.size() != 0) && (avail_q[0] <= cyc);
      if (inited) begin
        chk("req_ready", req_ready, exp_q.size() < FIFO_DEPTH);
        chk("busy", busy, exp_q.size() != 0);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("fpu_op", fpu_op, exp_op);
        chk("fpu_rmode", fpu_rmode, exp_rmode);
        chk("opa", opa, exp_opa);
        chk("opb", opb, exp_opb);
        if (exp_rv) begin
          h = exp_q[0];
          chk("rsp_data", rsp_data, h[TAG_W+31:TAG_W]);
          chk("rsp_flags", rsp_flags, h[EW-1 -: 8]);
          chk("rsp_tag", rsp_tag, h[TAG_W-1:0]);
        end
      end
      if (rst) begin
        exp_q.delete();
        avail_q.delete();
        exp_op = '0; exp_rmode = '0; exp_opa = '0; exp_opb = '0;
        inited = 1;
      end else if (inited) begin
        acc = req_valid && (exp_q.size() < FIFO_DEPTH);
        pp  = exp_rv && rsp_ready;
        if (pp) begin
          pop_tag_hist.push_back(int'(exp_q[0][TAG_W-1:0]));
          pop_cyc_hist.push_back(cyc);
          void'(exp_q.pop_front());
          void'(avail_q.pop_front());
        end
        if (acc) begin
          exp_q.push_back({core_fn(req_op, req_rmode, req_opa, req_opb), req_tag});
          avail_q.push_back(cyc + LATENCY + 2);
          exp_op = req_op; exp_rmode = req_rmode; exp_opa = req_opa; exp_opb = req_opb;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 2 time units after a rising edge.
  task automatic send(input logic [2:0] op, input logic [1:0] rm, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] t, output int waited);
    logic r;
    bit ok;
    req_valid = 1'b1; req_op = op; req_rmode = rm; req_opa = a; req_opb = b; req_tag = t;
    ok = 0;
    waited = 0;
    while (!ok && waited < 50) begin
      @(negedge clk); r = req_ready;
      @(posedge clk); #2;
      waited++;
      if (r) ok = 1;
    end
    req_valid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while ((busy || rsp_valid) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int w;
    int nacc;
    int prob;
    logic r;
    logic seen;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rmode = '0;
    req_opa = '0; req_opb = '0; req_tag = '0; rsp_ready = 1'b0;
    cycles(3);
    rst = 1'b0;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_fpu_op", fpu_op, 0);
    chk("reset_opa", opa, 0);
    chk("reset_rsp_data", rsp_data, 0);

    // Single add: response visible LATENCY+1 edges after the accept edge
    rsp_ready = 1'b1;
    send(3'd0, 2'd0, 32'h41C0_0000, 32'h4120_0000, 4'd5, w);
    cycles(LATENCY);
    chk("add_not_early", rsp_valid, 0);
    cycles(1);
    chk("add_valid", rsp_valid, 1);
    chk("add_data", rsp_data, 32'h4208_0000);
    chk("add_tag", rsp_tag, 5);
    chk("add_zero_flag", rsp_flags[0], 0);
    cycles(3);

    // Division: 24 / 10 = 2.4, inexact
    send(3'd3, 2'd0, 32'h41C0_0000, 32'h4120_0000, 4'd6, w);
    cycles(LATENCY + 1);
    chk("div_valid", rsp_valid, 1);
    chk("div_data", rsp_data, 32'h4019_999A);
    chk("div_ine", rsp_flags[4], 1);
    drain("div_drain", 20);

    // Back-to-back issue and in-order return
    pop_tag_hist.delete();
    pop_cyc_hist.delete();
    for (int t = 0; t < 4; t++) begin
      send(3'($urandom_range(0, 3)), 2'd0, $urandom, $urandom, 4'(t), w);
      chk("b2b_issue_one_cycle", w, 1);
    end
    drain("b2b_drain", 30);
    chk("b2b_count", pop_tag_hist.size(), 4);
    for (int i = 0; i < pop_tag_hist.size(); i++) begin
      chk("b2b_tag_order", pop_tag_hist[i], i);
      chk("b2b_consecutive", pop_cyc_hist[i] - pop_cyc_hist[0], i);
    end

    // Backpressure: six offers with no consumer, only FIFO_DEPTH accepted
    pop_tag_hist.delete();
    rsp_ready = 1'b0;
    nacc = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1; req_op = 3'($urandom_range(0, 3)); req_rmode = 2'($urandom_range(0, 3));
      req_opa = $urandom; req_opb = $urandom; req_tag = 4'(8 + nacc);
      @(negedge clk); r = req_ready;
      @(posedge clk); #2;
      if (r) nacc++;
    end
    req_valid = 1'b0;
    chk("bp_accepted", nacc, FIFO_DEPTH);
    chk("bp_ready_low", req_ready, 0);
    cycles(8);
    chk("bp_head_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    cycles(1);
    rsp_ready = 1'b0;
    chk("bp_ready_after_pop", req_ready, 1);
    send(3'd2, 2'd1, $urandom, $urandom, 4'd12, w);
    chk("bp_refill_ready_low", req_ready, 0);
    cycles(8);

    // Full FIFO: pop and offer together, the accept lands one edge later
    req_valid = 1'b1; req_op = 3'd1; req_rmode = 2'd2; req_opa = $urandom; req_opb = $urandom;
    req_tag = 4'd13; rsp_ready = 1'b1;
    @(negedge clk); r = req_ready;
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    chk("full_no_same_cycle_accept", r, 0);
    @(negedge clk); r = req_ready;
    @(posedge clk); #2;
    req_valid = 1'b0;
    chk("full_next_cycle_accept", r, 1);
    chk("full_again", req_ready, 0);
    drain("bp_drain", 40);
    chk("bp_pop_count", pop_tag_hist.size(), 6);
    for (int i = 0; i < pop_tag_hist.size(); i++) chk("bp_tag_order", pop_tag_hist[i], 8 + i);

    // Reset mid-flight: nothing accepted before it may come back
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) send(3'd0, 2'd3, $urandom, $urandom, 4'(t + 1), w);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_fpu_op", fpu_op, 0);
    chk("rst_fpu_rmode", fpu_rmode, 0);
    chk("rst_opa", opa, 0);
    chk("rst_opb", opb, 0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycles(1);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst_no_response", seen, 0);

    // Random traffic with alternating light and heavy consumer backpressure
    for (int c = 0; c < 1500; c++) begin
      prob = ((c / 300) % 2 == 0) ? 85 : 25;
      req_valid = ($urandom_range(0, 99) < 60);
      req_op = 3'($urandom_range(0, 3));
      req_rmode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        req_opa = 32'h41C0_0000; req_opb = 32'h4120_0000;
      end else begin
        req_opa = $urandom; req_opb = $urandom;
      end
      req_tag = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 99) < prob);
      rst = ($urandom_range(0, 399) == 0);
      cycles(1);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    drain("final_drain", 60);
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_issue_queue.md
Name: fpu_issue_queue

Overview:
Request/response front end for the single-precision fpu core. It accepts tagged operation requests on a valid/ready handshake and drives the core's operand and mode inputs. It tracks in-flight operations through the core's fixed pipeline latency, captures each result with its exception flags into a small output FIFO, and returns it on a valid/ready handshake. Credit-based backpressure ensures the FIFO never overflows, so the core itself needs no stall.

Parameters:
LATENCY, 4, cycles from operands presented at core inputs to corresponding result on fpu_out/flags (minimum 1)
FIFO_DEPTH, 4, result FIFO entries; also the maximum number of outstanding operations (power of 2, at least 2)
TAG_W, 4, request/response tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  3  fpu operation (0 add, 1 sub, 2 mul, 3 div)
req_rmode  in  2  rounding mode (0 nearest-even)
req_opa  in  32  operand A, IEEE-754 single
req_opb  in  32  operand B
req_tag  in  TAG_W  caller tag, returned with the result
fpu_op  out  3  to core
fpu_rmode  out  2  to core
opa  out  32  to core
opb  out  32  to core
fpu_out  in  32  core result
fpu_flags  in  8  core flags {snan,qnan,inf,ine,overflow,underflow,div_by_zero,zero}
rsp_valid  out  1  response available (FIFO not empty)
rsp_ready  in  1  consumer takes response
rsp_data  out  32  result
rsp_flags  out  8  flags, same order as fpu_flags
rsp_tag  out  TAG_W  tag of the request
busy  out  1  any operation in flight or any FIFO entry held

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: all outputs are 0 except req_ready, which is 1 once rst deasserts. fpu_op, fpu_rmode, opa and opb are 0. In-flight tracking and the FIFO are cleared; results emerging from the core afterwards are discarded. Reset mid-operation discards everything with no response.
- Accept: a request is accepted on a clock edge where req_valid and req_ready are both 1.
- Issue: on the accept edge, op/rmode/opa/opb are registered onto the core outputs. They hold their value until the next accept; idle cycles do not zero them.
- Tracking: the {valid, tag} pair enters a shift register of length LATENCY+1. An entry leaving the shift register captures fpu_out and fpu_flags into the FIFO on the same edge.
- Latency: a request accepted at edge N produces rsp_valid=1 after edge N+LATENCY+1, provided the FIFO was empty.
- Throughput: one request per cycle.
- Credits: outstanding = in-flight count + FIFO occupancy, range 0..FIFO_DEPTH. req_ready = (outstanding < FIFO_DEPTH), combinational from registered counts only, never from req_valid. A capture moves an entry from in-flight to FIFO, so outstanding is unchanged.
- Simultaneous events:
  - Accept and pop on the same edge: outstanding is unchanged.
  - Accept only: outstanding +1. Pop only: outstanding -1.
  - Capture and pop on the same edge when the FIFO is full is legal, because pop happens first logically.
- FIFO: first-word-fall-through. rsp_data, rsp_flags and rsp_tag show the head entry while rsp_valid=1 and hold stable until the pop (rsp_valid and rsp_ready both 1). Pointers wrap modulo FIFO_DEPTH. Responses are returned in acceptance order.
- Empty FIFO: rsp_valid=0 and response data are don't-care. A pop on an empty FIFO is ignored.
- busy = (outstanding != 0).
- Counters: the outstanding counter is clog2(FIFO_DEPTH)+1 bits wide, and must never underflow or exceed FIFO_DEPTH. Assert this in simulation.

Test Plan:
- Single op (model the core as an ideal LATENCY-stage pipeline). Accept add, opa=0x41C00000 (24), opb=0x41200000 (10), tag=5 at edge N, rsp_ready=1 -> rsp_valid=1 after edge N+5 with rsp_data=0x42080000, tag 5, zero flag 0; req_ready stays 1 throughout.
- Division. Op 3, opa=0x41C00000, opb=0x41200000, rmode 0 -> rsp_data=0x4019999A (2.4), ine=1.
- Back-to-back and ordering. Four requests on consecutive edges, tags 0..3, rsp_ready=1 -> four responses on consecutive cycles, tags 0,1,2,3, one issue per cycle.
- Backpressure. Hold rsp_ready=0 and offer 6 requests -> exactly FIFO_DEPTH=4 accepted and req_ready=0 from then on. Raise rsp_ready for one cycle -> one pop and req_ready=1 on the next cycle. All four results remain intact, none are lost or overwritten.
- Simultaneous accept and pop at full. With outstanding=4, pulse rsp_ready -> a same-cycle accept is not possible (req_ready=0); the next cycle accepts and outstanding returns to 4. Check the counter never exceeds 4.
- Reset mid-flight. Accept 3 requests, assert rst for 1 cycle at edge N+2 -> no rsp_valid ever appears for them. busy=0 and req_ready=1 after reset. fpu_op, fpu_rmode, opa and opb read 0.
